// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester beats and FIFO write port for the shared write-port arbiter
interface fifo_wr_arbiter_if #(
  parameter int DataWidth = 32,
  parameter int NumReq = 4
);
  localparam int IdWidth = $clog2(NumReq);
  logic [NumReq-1:0] req_valid;
  logic [NumReq-1:0] req_last;
  logic [NumReq*DataWidth-1:0] req_data;
  logic [NumReq-1:0] req_ready;
  logic wfull;
  logic winc;
  logic [IdWidth+DataWidth-1:0] wdata;
  logic [IdWidth-1:0] grant_id;
  logic busy;
  modport master(
    output req_valid, req_last, req_data, wfull,
    input req_ready, winc, wdata, grant_id, busy
  );
  modport slave(
    input req_valid, req_last, req_data, wfull,
    output req_ready, winc, wdata, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-locked sharing of one async-FIFO write port, beats tagged with source ID
module fifo_wr_arbiter #(
  parameter int DataWidth = 32,
  parameter int NumReq = 4,
  parameter int MaxBurst = 8
)(
  input logic wclk,
  input logic wrst_n,
  fifo_wr_arbiter_if.slave bus
);
  localparam int IdWidth = $clog2(NumReq);
  localparam int CntWidth = MaxBurst > 1 ? $clog2(MaxBurst) : 1;
  typedef enum logic {IDLE, GRANT} state_t;
  state_t r_state;
  logic [IdWidth-1:0] r_gnt, r_rr;
  logic [CntWidth-1:0] r_cnt;
  logic w_busy, w_acc, w_end, w_found;
  logic [IdWidth-1:0] w_nxt, w_base, w_win;
  logic [NumReq-1:0] w_pend;
  logic [2*NumReq-1:0] w_dbl;
  assign w_busy = r_state == GRANT;
  assign w_acc = w_busy & bus.req_valid[r_gnt] & ~bus.wfull;
  assign w_end = w_acc & (bus.req_last[r_gnt] | (r_cnt == CntWidth'(MaxBurst - 1)));
  assign w_nxt = (r_gnt == IdWidth'(NumReq - 1)) ? '0 : r_gnt + 1'b1;
  assign w_base = w_busy ? w_nxt : r_rr;
  // a requester that just sent its last beat is not considered still pending
  assign w_pend = (w_busy & bus.req_last[r_gnt]) ? bus.req_valid & ~(NumReq'(1) << r_gnt) : bus.req_valid;
  assign w_dbl = {w_pend, w_pend} >> w_base;
  always_comb begin
    w_found = 1'b0;
    w_win = w_base;
    for (int k = NumReq - 1; k >= 0; k--)
      if (w_dbl[k]) begin
        w_found = 1'b1;
        w_win = IdWidth'(int'(w_base) + k - ((int'(w_base) + k >= NumReq) ? NumReq : 0));
      end
  end
  always_ff @(posedge wclk or negedge wrst_n)
    if (!wrst_n) begin
      r_state <= IDLE;
      r_gnt <= '0;
      r_rr <= '0;
      r_cnt <= '0;
    end else if (!w_busy) begin
      if (w_found) begin
        r_state <= GRANT;
        r_gnt <= w_win;
      end
    end else if (w_end) begin
      r_cnt <= '0;
      r_rr <= w_nxt;
      if (w_found) r_gnt <= w_win;
      else r_state <= IDLE;
    end else if (w_acc) r_cnt <= r_cnt + 1'b1;
  assign bus.winc = w_acc;
  assign bus.req_ready = w_acc ? NumReq'(1) << r_gnt : '0;
  assign bus.wdata = {r_gnt, bus.req_data[r_gnt*DataWidth +: DataWidth]};
  assign bus.grant_id = r_gnt;
  assign bus.busy = w_busy;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed checks of grant order, burst limits, backpressure, wrap and reset
module tb_fifo_wr_arbiter;
  localparam int DW = 8;
  typedef struct {
    logic [3:0] v;
    logic full;
    int g;
    logic w;
  } vec_t;
  logic wclk = 1'b0;
  logic wrst_n = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  int cnt[4];
  int blen[4];
  vec_t vq[$];
  always #5 wclk = ~wclk;
  fifo_wr_arbiter_if #(.DataWidth(DW), .NumReq(4)) a();
  fifo_wr_arbiter_if #(.DataWidth(DW), .NumReq(3)) b();
  fifo_wr_arbiter #(.DataWidth(DW), .NumReq(4), .MaxBurst(8)) u_a(.wclk(wclk), .wrst_n(wrst_n), .bus(a.slave));
  fifo_wr_arbiter #(.DataWidth(DW), .NumReq(3), .MaxBurst(8)) u_b(.wclk(wclk), .wrst_n(wrst_n), .bus(b.slave));
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask
  task automatic push(input logic [3:0] v, input logic full, input int g, input logic w, input int n);
    vec_t e;
    e.v = v;
    e.full = full;
    e.g = g;
    e.w = w;
    for (int i = 0; i < n; i++) vq.push_back(e);
  endtask
  task automatic rst_seq(input logic [3:0] v0);
    wrst_n = 1'b0;
    a.req_valid = '0;
    a.req_last = '0;
    a.wfull = 1'b0;
    b.req_valid = '0;
    b.req_last = '0;
    b.wfull = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0;
      blen[i] = 0;
    end
    vq.delete();
    @(posedge wclk);
    @(posedge wclk);
    #1;
  endtask
  task automatic drive(input bit sel, input logic [3:0] v, input logic full);
    logic [3:0] last;
    logic [4*DW-1:0] d;
    for (int i = 0; i < 4; i++) begin
      last[i] = blen[i] != 0 && (cnt[i] % blen[i]) == blen[i] - 1;
      d[i*DW +: DW] = DW'(i * 16 + cnt[i]);
    end
    if (sel) begin
      b.req_valid = v[2:0];
      b.req_last = last[2:0];
      b.req_data = d[3*DW-1:0];
      b.wfull = full;
    end else begin
      a.req_valid = v;
      a.req_last = last;
      a.req_data = d;
      a.wfull = full;
    end
  endtask
  task automatic run(input bit sel, input string name);
    vec_t e;
    logic [3:0] rdy;
    logic [9:0] ew;
    for (int c = 0; c < vq.size(); c++) begin
      e = vq[c];
      drive(sel, e.v, e.full);
      #1;
      rdy = sel ? {1'b0, b.req_ready} : a.req_ready;
      ew = {2'(e.g), 8'(e.g * 16 + cnt[e.g])};
      check($sformatf("%s c%0d grant_id", name, c), sel ? 32'(b.grant_id) : 32'(a.grant_id), e.g);
      check($sformatf("%s c%0d winc", name, c), sel ? 32'(b.winc) : 32'(a.winc), 32'(e.w));
      check($sformatf("%s c%0d req_ready", name, c), 32'(rdy), e.w ? 32'(1) << e.g : 32'(0));
      check($sformatf("%s c%0d wdata", name, c), sel ? 32'(b.wdata) : 32'(a.wdata), 32'(ew));
      @(posedge wclk);
      for (int i = 0; i < 4; i++) if (rdy[i]) cnt[i]++;
      #1;
    end
  endtask
  task automatic release_rst(input bit sel);
    drive(sel, vq[0].v, vq[0].full);
    wrst_n = 1'b1;
    #1;
    check("release busy before edge", sel ? 32'(b.busy) : 32'(a.busy), 0);
    @(posedge wclk);
    #1;
  endtask
  initial begin
    a.req_data = '0;
    b.req_data = '0;
    #1;
    rst_seq(4'hF);
    a.req_valid = 4'hF;
    repeat (3) @(posedge wclk);
    #1;
    check("reset winc", 32'(a.winc), 0);
    check("reset req_ready", 32'(a.req_ready), 0);
    check("reset busy", 32'(a.busy), 0);
    check("reset grant_id", 32'(a.grant_id), 0);
    for (int i = 0; i < 4; i++) blen[i] = 2;
    for (int c = 0; c < 10; c++) push(4'hF, 1'b0, (c / 2) % 4, 1'b1, 1);
    release_rst(0);
    run(0, "fair");
    rst_seq(4'b0110);
    blen[2] = 1;
    push(4'b0110, 1'b0, 1, 1'b1, 8);
    push(4'b0110, 1'b0, 2, 1'b1, 1);
    push(4'b0110, 1'b0, 1, 1'b1, 8);
    push(4'b0110, 1'b0, 2, 1'b1, 1);
    release_rst(0);
    run(0, "maxburst");
    rst_seq(4'b1001);
    blen[3] = 1;
    push(4'b1001, 1'b0, 0, 1'b1, 2);
    push(4'b1001, 1'b1, 0, 1'b0, 5);
    push(4'b1001, 1'b0, 0, 1'b1, 6);
    push(4'b1001, 1'b0, 3, 1'b1, 1);
    push(4'b1001, 1'b0, 0, 1'b1, 1);
    release_rst(0);
    run(0, "backpressure");
    rst_seq(4'b0100);
    blen[2] = 2;
    blen[0] = 1;
    push(4'b0100, 1'b0, 2, 1'b1, 1);
    push(4'b0101, 1'b0, 2, 1'b1, 1);
    push(4'b0101, 1'b0, 0, 1'b1, 1);
    push(4'b0101, 1'b0, 2, 1'b1, 2);
    push(4'b0101, 1'b0, 0, 1'b1, 1);
    release_rst(1);
    run(1, "wrap3");
    rst_seq(4'b0011);
    push(4'b0011, 1'b0, 0, 1'b1, 3);
    release_rst(0);
    run(0, "midreset");
    drive(0, 4'b0011, 1'b0);
    #1;
    check("beat3 winc", 32'(a.winc), 1);
    wrst_n = 1'b0;
    #1;
    check("async reset winc", 32'(a.winc), 0);
    check("async reset req_ready", 32'(a.req_ready), 0);
    check("async reset busy", 32'(a.busy), 0);
    check("async reset grant_id", 32'(a.grant_id), 0);
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
    #1;
    check("resume busy before edge", 32'(a.busy), 0);
    @(posedge wclk);
    #1;
    check("resume grant_id", 32'(a.grant_id), 0);
    check("resume busy", 32'(a.busy), 1);
    check("resume winc", 32'(a.winc), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
